// File: rtl/alu_stream.sv
// rtl/alu_stream.sv - WIDTH-bit ALU with a registered compute stage and a DEPTH-entry response FIFO.
// Optional feature macro: ALU_ERR_EN (adds o_resp_err, flags opcode 7).
module alu_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [2:0]         i_req_op,
  input  logic [WIDTH-1:0]   i_req_op1,
  input  logic [WIDTH-1:0]   i_req_op2,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [2*WIDTH-1:0] o_resp_result
`ifdef ALU_ERR_EN
  ,
  output logic               o_resp_err
`endif
);

  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(RW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [RW-1:0] w_a;
  logic [RW-1:0] w_b;
  logic [RW-1:0] w_alu;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [CW:0]   w_occ_next;

  logic          r_req_ready;
  logic          r_s1_valid;
  logic [RW-1:0] r_s1_result;
  logic [RW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_a   = {{WIDTH{1'b0}}, i_req_op1};
    w_b   = {{WIDTH{1'b0}}, i_req_op2};
    w_alu = '0;
    case (i_req_op)
      3'd0:    w_alu = w_a + w_b;
      3'd1:    w_alu = w_a - w_b;
      3'd2:    w_alu = w_a & w_b;
      3'd3:    w_alu = w_a | w_b;
      3'd4:    w_alu = w_a ^ w_b;
      3'd5:    w_alu = w_a * w_b;
      3'd6:    w_alu = w_a << i_req_op2[SW-1:0];
      default: w_alu = '0;
    endcase
  end

  // S1 never stalls: ready already guarantees a FIFO slot for whatever sits in S1.
  assign w_acc        = i_req_valid & r_req_ready;
  assign w_push       = r_s1_valid;
  assign w_pop        = o_resp_valid & i_resp_ready;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_occ_next   = (CW+1)'(w_count_next) + (CW+1)'(w_acc);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req_ready <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_result <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_req_ready <= w_occ_next < (CW+1)'(DEPTH);
      r_s1_valid  <= w_acc;
      if (w_acc) r_s1_result <= w_alu;
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      r_count     <= w_count_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s1_result;
  end

  assign o_req_ready   = r_req_ready;
  assign o_resp_valid  = (r_count != '0);
  assign o_resp_result = o_resp_valid ? r_mem[r_rd_ptr] : '0;

`ifdef ALU_ERR_EN
  logic w_illegal;
  logic r_s1_err;
  logic r_err_mem [DEPTH];

  assign w_illegal = (i_req_op == 3'd7);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_s1_err <= 1'b0;
    else if (w_acc) r_s1_err <= w_illegal;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_err_mem[r_wr_ptr] <= r_s1_err;
  end

  assign o_resp_err = o_resp_valid ? r_err_mem[r_rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_alu_stream.sv
// tb/tb_alu_stream.sv - scoreboard bench for alu_stream (WIDTH=8, DEPTH=4); honours ALU_ERR_EN.
module tb_alu_stream;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_op1;
  logic [W-1:0]  req_op2;
  logic          resp_valid;
  logic          resp_ready;
  logic [RW-1:0] resp_result;
`ifdef ALU_ERR_EN
  logic          resp_err;
`endif

  alu_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_op1(req_op1), .i_req_op2(req_op2),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_result(resp_result)
`ifdef ALU_ERR_EN
    , .o_resp_err(resp_err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [RW:0] q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: plain unsigned arithmetic, truncated to RW bits; bit RW is the illegal-op flag.
  function automatic logic [RW:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned x, y, r;
    x = a;
    y = b;
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x * y;
      3'd6: r = x << (y % RW);
      default: r = 0;
    endcase
    return {op == 3'd7, RW'(r)};
  endfunction

  // Called just after a falling edge; req_ready is registered so it is stable here.
  task automatic drive(input bit v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RW:0] exp, output bit acc);
    req_valid = v;
    req_op    = op;
    req_op1   = a;
    req_op2   = b;
    acc = v && req_ready;
    if (acc) q.push_back(exp);
  endtask

  // Monitor: pops and compares whenever the DUT hands over a response.
  logic          prev_hold = 1'b0;
  logic [RW-1:0] prev_res  = '0;
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", resp_valid, 1);
        chk("hold_result", resp_result, prev_res);
      end
      if (!resp_valid) chk("idle_result_zero", resp_result, 0);
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_resp_qsize", q.size(), 1);
        end else begin
          logic [RW:0] e;
          e = q.pop_front();
          chk("resp_result", resp_result, e[RW-1:0]);
`ifdef ALU_ERR_EN
          chk("resp_err", resp_err, e[RW]);
`endif
          n_pop++;
        end
      end
      prev_hold = resp_valid && !resp_ready;
      prev_res  = resp_result;
    end
  end

  task automatic single(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW:0] exp);
    bit acc;
    @(negedge clk);
    drive(1, op, a, b, exp, acc);
    chk("single_accept", acc, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, acc);
    chk("latency_edge_n", resp_valid, 0);
    @(negedge clk);
    chk("latency_edge_n1", resp_valid, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, acc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, pops_before, sent, cyc;
    logic [2:0] op;
    logic [W-1:0] a, b;

    rst = 1'b1; req_valid = 0; req_op = 0; req_op1 = 0; req_op2 = 0; resp_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_result", resp_result, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", req_ready, 1);

    resp_ready = 1;
    single(3'd0, 8'hFF, 8'h01, {1'b0, 16'h0100});
    single(3'd1, 8'h03, 8'h05, {1'b0, 16'hFFFE});
    single(3'd5, 8'hFF, 8'hFF, {1'b0, 16'hFE01});
    single(3'd6, 8'h81, 8'h09, {1'b0, 16'h0200});
    single(3'd4, 8'hF0, 8'h3C, {1'b0, 16'h00CC});
`ifdef ALU_ERR_EN
    single(3'd7, 8'h12, 8'h34, {1'b1, 16'h0000});
`else
    single(3'd7, 8'h12, 8'h34, {1'b0, 16'h0000});
`endif
    idle(2);

    // Backpressure: consumer stalled, request held.
    resp_ready = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, 3'd0, W'(i), W'(i + 1), model(3'd0, W'(i), W'(i + 1)), acc);
      n += int'(acc);
    end
    chk("bp_accepts", n, 4);
    chk("bp_ready_low", req_ready, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, acc);
    resp_ready = 1;
    @(negedge clk);
    chk("bp_ready_after_pop", req_ready, 1);
    idle(6);
    chk("bp_drained", q.size(), 0);

    // Streaming: back-to-back ADDs with the consumer always ready.
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1, 3'd0, W'(i), W'(i), {1'b0, RW'(2 * i)}, acc);
      n += int'(acc);
    end
    chk("stream_accepts", n, 16);
    idle(4);
    chk("stream_drained", q.size(), 0);

    // Simultaneous push/pop at DEPTH-1 occupancy.
    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 3'd2, W'(8'hA5 + i), 8'h0F, model(3'd2, W'(8'hA5 + i), 8'h0F), acc);
    end
    idle(2);
    chk("pp_ready_at_3", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      resp_ready = 1;
      drive(1, 3'd3, W'(i * 7), W'(i * 3), model(3'd3, W'(i * 7), W'(i * 3)), acc);
      chk("pp_accept", acc, 1);
      chk("pp_valid", resp_valid, 1);
    end
    idle(6);
    chk("pp_drained", q.size(), 0);

    // Reset with three entries queued.
    resp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 3'd5, W'(i + 2), 8'h11, model(3'd5, W'(i + 2), 8'h11), acc);
    end
    idle(2);
    chk("rst_pre_valid", resp_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", resp_valid, 0);
    chk("rst_mid_result", resp_result, 0);
    chk("rst_mid_ready", req_ready, 0);
    q.delete();
    pops_before = n_pop;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_after_release", req_ready, 1);
    resp_ready = 1;
    idle(5);
    chk("rst_no_stale", n_pop, pops_before);

    // Random traffic with pauses on both sides.
    sent = 0;
    cyc = 0;
    while (sent < 400 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      resp_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      drive($urandom_range(0, 2) != 0, op, a, b, model(op, a, b), acc);
      sent += int'(acc);
    end
    chk("rand_sent", sent, 400);
    resp_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, acc);
      n++;
    end
    idle(2);
    chk("rand_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
